// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshake on both sides.
// One result stage carries the sum/logic result, carry/zero/overflow flags and a sticky overflow bit.
module alu_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SW  = WIDTH + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  logic             xfer;
  logic [SW-1:0]    add_full;
  logic [SW-1:0]    sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_ovf;
  logic             res_z;

  // The result register may refill in the same cycle it is drained.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Result and flags for the operand bundle presented this cycle.
  always_comb begin
    add_full = {1'b0, in_x} + {1'b0, in_y} + SW'(in_c);
    sub_full = {1'b0, in_x} + {1'b0, ~in_y} + SW'(1);
    add_ovf  = (in_x[MSB] == in_y[MSB]) && (add_full[MSB] != in_x[MSB]);
    sub_ovf  = (in_x[MSB] != in_y[MSB]) && (sub_full[MSB] != in_x[MSB]);
    lt       = sub_full[MSB] ^ sub_ovf;
    res_s    = '0;
    res_c    = 1'b0;
    res_ovf  = 1'b0;
    case (select)
      OP_ADD: begin
        res_s   = add_full[WIDTH-1:0];
        res_c   = add_full[WIDTH];
        res_ovf = add_ovf;
      end
      OP_SUB: begin
        res_s   = sub_full[WIDTH-1:0];
        res_c   = sub_full[WIDTH];
        res_ovf = sub_ovf;
      end
      OP_NOT: res_s = ~in_x;
      OP_AND: res_s = in_x & in_y;
      OP_OR:  res_s = in_x | in_y;
      OP_XOR: res_s = in_x ^ in_y;
      OP_LT:  res_s = WIDTH'(lt);
      OP_EQ:  res_s = WIDTH'(in_x == in_y);
    endcase
    res_z = (res_s == '0);
  end

  // Output stage: load on transfer, drop valid on a handoff with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_c     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_s     <= res_s;
      out_c     <= res_c;
      zero      <= res_z;
      overflow  <= res_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (xfer && res_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 4-bit and an 8-bit instance share the stimulus;
// each vector's hand-computed result is checked on the instance whose width it targets.
module tb_alu_pipe;

  typedef struct {
    int unsigned w;
    logic [2:0]  op;
    logic        c;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  s;
    logic        ec;
    logic        ez;
    logic        eo;
  } vec_t;

  typedef struct {
    int unsigned w;
    int          id;
    logic [7:0]  s;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] select;
  logic       in_c;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       out_ready;
  logic       clr_sticky;

  logic       rdy4, ov4, c4, z4, o4, st4;
  logic [3:0] s4;
  logic       rdy8, ov8, c8, z8, o8, st8;
  logic [7:0] s8;

  exp_t q4[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops4  = 0;
  int   pops8  = 0;

  vec_t vecs[16];
  vec_t bp[5];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .select(select), .in_c(in_c), .in_x(in_x[3:0]), .in_y(in_y[3:0]),
    .out_valid(ov4), .out_ready(out_ready), .out_s(s4), .out_c(c4),
    .zero(z4), .overflow(o4), .ovf_sticky(st4), .clr_sticky(clr_sticky)
  );

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .select(select), .in_c(in_c), .in_x(in_x), .in_y(in_y),
    .out_valid(ov8), .out_ready(out_ready), .out_s(s8), .out_c(c8),
    .zero(z8), .overflow(o8), .ovf_sticky(st8), .clr_sticky(clr_sticky)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one bundle, wait for acceptance, queue its expected result on both sides.
  task automatic send(input vec_t v, input int id, output int waited);
    exp_t e;
    in_valid = 1'b1;
    select   = v.op;
    in_c     = v.c;
    in_x     = v.x;
    in_y     = v.y;
    waited   = 0;
    @(negedge clk);
    while (!rdy4 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!rdy4) begin
      chk("send_timeout", 32'(rdy4), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = '{w: v.w, id: id, s: v.s, c: v.ec, z: v.ez, o: v.eo};
    q4.push_back(e);
    q8.push_back(e);
    pushes++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("latency_out_valid", {30'd0, ov4, ov8}, 32'd3);
  endtask

  // Monitors: every handoff pops one expected entry per instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov4 && out_ready) begin
      pops4++;
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon4_unexpected: got s=%h with empty queue", s4);
      end else begin
        e = q4.pop_front();
        if (e.w == 4) begin
          checks++;
          if ({s4, c4, z4, o4} !== {e.s[3:0], e.c, e.z, e.o}) begin
            errors++;
            $display("FAIL mon4 id=%0d: got s=%h c=%b z=%b o=%b expected s=%h c=%b z=%b o=%b",
                     e.id, s4, c4, z4, o4, e.s[3:0], e.c, e.z, e.o);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov8 && out_ready) begin
      pops8++;
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon8_unexpected: got s=%h with empty queue", s8);
      end else begin
        e = q8.pop_front();
        if (e.w == 8) begin
          checks++;
          if ({s8, c8, z8, o8} !== {e.s, e.c, e.z, e.o}) begin
            errors++;
            $display("FAIL mon8 id=%0d: got s=%h c=%b z=%b o=%b expected s=%h c=%b z=%b o=%b",
                     e.id, s8, c8, z8, o8, e.s, e.c, e.z, e.o);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    //            w  op    c     x      y      s      c     z     o
    vecs[0]  = '{4, 3'd0, 1'b0, 8'h07, 8'h01, 8'h08, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4, 3'd1, 1'b1, 8'h03, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4, 3'd1, 1'b0, 8'h08, 8'h01, 8'h07, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{4, 3'd0, 1'b1, 8'h0F, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4, 3'd0, 1'b0, 8'h08, 8'h08, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{4, 3'd2, 1'b1, 8'h0A, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4, 3'd3, 1'b0, 8'h0C, 8'h0A, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4, 3'd4, 1'b0, 8'h0C, 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4, 3'd6, 1'b0, 8'h07, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4, 3'd7, 1'b0, 8'h03, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8, 3'd6, 1'b0, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8, 3'd7, 1'b0, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8, 3'd5, 1'b0, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{8, 3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8, 3'd1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{8, 3'd6, 1'b0, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0};
    bp[0]    = '{4, 3'd0, 1'b0, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0};
    bp[1]    = '{4, 3'd1, 1'b0, 8'h05, 8'h07, 8'h0E, 1'b0, 1'b0, 1'b0};
    bp[2]    = '{4, 3'd5, 1'b0, 8'h06, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0};
    bp[3]    = '{4, 3'd0, 1'b0, 8'h04, 8'h04, 8'h08, 1'b0, 1'b0, 1'b1};
    bp[4]    = '{4, 3'd4, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    select     = 3'd0;
    in_c       = 1'b0;
    in_x       = 8'h00;
    in_y       = 8'h00;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;

    #1;
    chk("reset_outputs4", {26'd0, ov4, s4, c4, z4, o4, st4}, 32'd0);
    chk("reset_outputs8", {22'd0, ov8, s8, c8, z8, o8, st8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {30'd0, rdy4, rdy8}, 32'd3);
    @(posedge clk);
    #1;

    // Directed operations at full throughput.
    send(vecs[0], 0, waited);
    @(negedge clk);
    chk("sticky_after_add_ovf", 32'(st4), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 16; i++) send(vecs[i], i, waited);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: result held, input stalled, then back-to-back drain.
    out_ready = 1'b0;
    send(bp[0], 100, waited);
    in_valid = 1'b1;
    select   = bp[1].op;
    in_c     = bp[1].c;
    in_x     = bp[1].x;
    in_y     = bp[1].y;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(rdy4), 32'd0);
      chk("bp_out_s_stable", {27'd0, ov4, s4}, 32'h15);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      send(bp[i], 100 + i, waited);
      chk("bp_no_bubble", 32'(waited), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Sticky: standalone clear, then set wins over a same-cycle clear.
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(st4), 32'd0);
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    send(vecs[0], 200, waited);
    @(negedge clk);
    chk("sticky_set_wins", 32'(st4), 32'd1);
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clear_alone", 32'(st4), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held under backpressure.
    out_ready = 1'b0;
    send(vecs[0], 300, waited);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset4", {26'd0, ov4, s4, c4, z4, o4, st4}, 32'd0);
    chk("async_reset8", {22'd0, ov8, s8, c8, z8, o8, st8}, 32'd0);
    void'(q4.pop_back());
    void'(q8.pop_back());
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_async_reset", {30'd0, rdy4, rdy8}, 32'd3);
    @(posedge clk);
    #1;
    send(vecs[10], 400, waited);
    send(vecs[2], 401, waited);
    repeat (3) @(posedge clk);
    #1;

    chk("queue4_drained", 32'(q4.size()), 32'd0);
    chk("queue8_drained", 32'(q8.size()), 32'd0);
    chk("handoffs4", 32'(pops4), 32'(pushes - 1));
    chk("handoffs8", 32'(pops8), 32'(pushes - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational adder/ALU.
- Performs WIDTH-bit add, subtract, logic and compare operations on a valid/ready input stream.
- Produces one registered result stage with carry/zero/overflow flags, plus a sticky overflow status bit.
- Sits between the operand source (switch/register logic) and the display or writeback consumer.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept an operand bundle this cycle.
- select  input  3  operation code (see Behaviour).
- in_c  input  1  carry-in; used by ADD only.
- in_x  input  WIDTH  operand A (two's complement).
- in_y  input  WIDTH  operand B (two's complement).
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_s  output  WIDTH  result.
- out_c  output  1  carry flag.
- zero  output  1  out_s == 0.
- overflow  output  1  signed overflow flag.
- ovf_sticky  output  1  set by any accepted result with overflow = 1; held until cleared.
- clr_sticky  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (asynchronous, rst_n = 0): out_valid, out_s, out_c, zero, overflow and ovf_sticky all go to 0 immediately. in_ready is 1 once reset is released. Reset mid-transfer discards the held result with no output.
- Accept rule: in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready.
- Latency: 1 cycle. On transfer, the result and flags are registered, and out_valid = 1 on the next cycle.
- Hold: while out_valid && !out_ready, out_s and all flags stay stable and no new input is accepted.
- Simultaneous output handoff and new input (out_ready = 1, in_valid = 1 with out_valid = 1): new result loads the same cycle; out_valid stays 1; no bubble. Full throughput is 1 op/cycle.
- Output handoff without new input (out_ready = 1, no transfer): out_valid -> 0. The data registers keep their last values (don't care).
- Operations (select):
  - 0 ADD: {out_c, out_s} = in_x + in_y + in_c, computed WIDTH+1 bits wide. overflow = (x[msb] == y[msb]) && (s[msb] != x[msb]).
  - 1 SUB: out_s = in_x + ~in_y + 1, wrapping modulo 2^WIDTH; in_c is ignored. out_c = carry out (1 means no borrow). overflow = (x[msb] != y[msb]) && (s[msb] != x[msb]).
  - 2 NOT: out_s = ~in_x.
  - 3 AND: out_s = in_x & in_y.
  - 4 OR: out_s = in_x | in_y.
  - 5 XOR: out_s = in_x ^ in_y.
  - 6 LT: out_s = {0..., signed(in_x) < signed(in_y)}. Computed via subtraction: lt = s[msb] ^ overflow_sub.
  - 7 EQ: out_s = {0..., in_x == in_y}.
  - For ops 2-7, out_c = 0 and overflow = 0.
- zero is computed from the final out_s for every op.
- ovf_sticky update per cycle:
  - set on transfer with computed overflow = 1;
  - cleared when clr_sticky = 1 and no set condition that cycle;
  - set wins if both occur in the same cycle.
- select and all other inputs are sampled only on transfer cycles; values outside transfers are ignored.

Test Plan:
- WIDTH=4, ADD x=0111 y=0001 in_c=0 -> next cycle out_valid=1, out_s=1000, out_c=0, zero=0, overflow=1, ovf_sticky=1.
- WIDTH=4, SUB x=0011 y=0011 -> out_s=0000, out_c=1, zero=1, overflow=0; SUB x=1000 y=0001 -> out_s=0111, overflow=1.
- WIDTH=8, LT x=0xFE(-2) y=0x01 -> out_s=0x01. EQ x=y=0x5A -> out_s=0x01, zero=0. XOR x=y -> out_s=0x00, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_s stable. Raise out_ready -> back-to-back transfers at 1 result/cycle, none lost or duplicated, matched against a reference queue.
- Same cycle: an overflowing ADD transfer with clr_sticky=1 -> ovf_sticky=1 next cycle. clr_sticky alone on the following cycle -> 0.
- Assert rst_n=0 while out_valid=1 && out_ready=0 -> all outputs 0 immediately, without waiting for a clk edge. After release, in_ready=1 and the first new op has 1-cycle latency.
